// File: rtl/imem_arb_pkg.sv
// Shared constants and tag-pipe entry type for the instruction-memory fetch arbiter.
package imem_arb_pkg;

  localparam int DEF_NUM_PORTS   = 4;
  localparam int DEF_ADDR_W      = 20;
  localparam int DEF_DATA_W      = 128;
  localparam int DEF_MEM_LATENCY = 1;

  // Tag field is sized for the largest legal port count (16).
  localparam int MAX_TAG_W = 4;

  function automatic int tag_w(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  typedef struct packed {
    logic                 v;
    logic [MAX_TAG_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/imem_fetch_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set pending bit at or after rr_ptr, with wrap.
module rr_arbiter
  import imem_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int TAG_W     = tag_w(DEF_NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] pend,
  input  logic [TAG_W-1:0]     rr_ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [TAG_W-1:0]     grant_idx,
  output logic                 grant_vld
);

  int               idx;
  logic [TAG_W-1:0] idx_t;

  // Scan from the farthest offset down so the nearest set bit wins last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    idx_t     = '0;
    for (int off = NUM_PORTS - 1; off >= 0; off--) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      idx_t = TAG_W'(idx);
      if (pend[idx_t]) begin
        grant_idx = idx_t;
        grant_vld = 1'b1;
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares one fixed-latency instruction memory between NUM_PORTS fetch requesters;
// one queued fetch per port, round-robin grant, tag-routed responses.
module imem_fetch_arbiter
  import imem_arb_pkg::*;
#(
  parameter int NUM_PORTS   = DEF_NUM_PORTS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_re,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  output logic [NUM_PORTS-1:0]        resp_valid,
  output logic [DATA_W-1:0]           resp_data,
  output logic                        mem_re,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_valid,
  output logic                        busy,
  output logic                        proto_err,
  output logic                        resp_err
);

  localparam int TAG_W   = tag_w(NUM_PORTS);
  localparam int DRAIN_W = $clog2(MEM_LATENCY + 1);

  logic [NUM_PORTS-1:0] pend_q;
  logic [ADDR_W-1:0]    addr_q [NUM_PORTS];
  logic [TAG_W-1:0]     rr_ptr_q;
  logic [NUM_PORTS-1:0] grant;
  logic [TAG_W-1:0]     grant_idx;
  logic                 grant_vld;
  logic [NUM_PORTS-1:0] blocked;
  tag_entry_t           issue_q;
  tag_entry_t           pipe_q [MEM_LATENCY];
  tag_entry_t           head;
  logic [DRAIN_W-1:0]   drain_q;
  logic                 pipe_busy;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .TAG_W     (TAG_W)
  ) u_rr (
    .pend      (pend_q),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // A request collides only if its port stays pending through this edge.
  assign blocked = req_re & pend_q & ~grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      rr_ptr_q  <= '0;
      issue_q   <= '0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      proto_err <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) addr_q[i] <= '0;
    end else begin
      pend_q <= (pend_q & ~grant) | req_re;
      if (|blocked) proto_err <= 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (req_re[i] && !blocked[i]) addr_q[i] <= req_addr[i*ADDR_W +: ADDR_W];
      end
      mem_re      <= grant_vld;
      issue_q.v   <= grant_vld;
      issue_q.tag <= MAX_TAG_W'(grant_idx);
      if (grant_vld) begin
        mem_addr <= addr_q[grant_idx];
        rr_ptr_q <= (grant_idx == TAG_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // issue_q is the grant-edge stage; pipe_q adds MEM_LATENCY more so the head
  // lines up with mem_valid for a grant MEM_LATENCY+1 edges earlier.
  assign head = pipe_q[MEM_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MEM_LATENCY; k++) pipe_q[k] <= '0;
      drain_q    <= DRAIN_W'(MEM_LATENCY);
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      pipe_q[0] <= issue_q;
      for (int k = 1; k < MEM_LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
      resp_valid <= '0;
      if (drain_q != '0) begin
        drain_q <= drain_q - 1'b1;
      end else if (head.v && mem_valid) begin
        resp_valid <= NUM_PORTS'(1) << head.tag;
        resp_data  <= mem_rdata;
      end else if (head.v != mem_valid) begin
        resp_err <= 1'b1;
      end
    end
  end

  always_comb begin
    pipe_busy = issue_q.v;
    for (int k = 0; k < MEM_LATENCY; k++) pipe_busy = pipe_busy | pipe_q[k].v;
  end

  assign busy = (|pend_q) | pipe_busy;

endmodule

// File: doc/imem_fetch_arbiter.md
Name: imem_fetch_arbiter

Overview:
Shares one instruction memory between NUM_PORTS local command processors (LCPs). Each LCP keeps its own imem_re/imem_addr/imem_valid/imem_data handshake. The block queues one fetch per port, grants ports round-robin onto a fixed-latency memory, and routes each returned word to its requester by tag. It sits between the LCP array and the shared instruction SRAM.

Parameters:
NUM_PORTS, 4, number of requesting LCPs (2..16)
ADDR_W, 20, fetch address width
DATA_W, 128, instruction word width
MEM_LATENCY, 1, edges from mem_re sampled by memory to mem_valid (1..4)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_re  in  NUM_PORTS  per-port fetch strobe, one cycle
req_addr  in  NUM_PORTS*ADDR_W  per-port address; port i in bits [i*ADDR_W +: ADDR_W]
resp_valid  out  NUM_PORTS  one-hot response strobe
resp_data  out  DATA_W  response word, shared by all ports, qualified by resp_valid
mem_re  out  1  memory read strobe
mem_addr  out  ADDR_W  memory address
mem_rdata  in  DATA_W  memory data
mem_valid  in  1  memory data valid
busy  out  1  any pending or in-flight fetch
proto_err  out  1  sticky: req_re while own fetch is still pending
resp_err  out  1  sticky: mem_valid disagrees with tag pipe

Behaviour:
- Reset: all outputs 0; pending bits, tag pipe and rr_ptr cleared (rr_ptr=0); drain counter loaded with MEM_LATENCY.
- Accept: req_re[i] sampled at edge t sets pend[i] and latches addr[i].
  - If pend[i] is already set and not granted at edge t: drop the request, keep the old address, set proto_err.
  - If pend[i] is granted at the same edge, the set takes priority: the new request is accepted with no error.
- Grant: one per edge at most. Winner is the first set pend bit at or after rr_ptr, with wrap.
  - Registers mem_re=1 and mem_addr=addr[g], clears pend[g], sets rr_ptr=(g+1) mod NUM_PORTS.
  - Pushes {1,g} into the tag pipe.
  - No pend bit set: mem_re=0, mem_addr holds, push {0,x}.
- Tag pipe: shift register, depth MEM_LATENCY, entry {v, tag[clog2(NUM_PORTS)-1:0]}. It aligns so its head meets mem_valid for the grant issued MEM_LATENCY+1 edges earlier.
- Return, at each edge:
  - head.v and mem_valid both set: resp_valid=onehot(head.tag), resp_data=mem_rdata, both registered.
  - Exactly one of the two set: resp_err=1, no resp_valid.
  - resp_valid is a single-cycle pulse. resp_data holds between responses.
- Latency: uncontended, req_re at edge t gives mem_re high after edge t+1 and resp_valid high after edge t+2+MEM_LATENCY (t+3 for default).
- Throughput: one grant per cycle. The pipe never stalls because memory latency is fixed.
- Drain: for MEM_LATENCY edges after rst deasserts, mem_valid is ignored with no error. Fetches in flight across a reset are discarded.
- busy = |pend | any pipe v.
- proto_err and resp_err clear only on rst.

Decomposition:
- Package imem_arb_pkg holds default parameter constants, the TAG_W=$clog2(NUM_PORTS) helper, and the tag-pipe entry struct {v, tag}.
- Sub-module rr_arbiter: NUM_PORTS-wide pending vector plus rr_ptr in; one-hot grant and index out; combinational; rr_ptr register stays in the parent.
- Tag pipe and pend/addr registers live in the top.

Test Plan:
1. Port 2 req_re, addr=0x00010; memory returns {8'hFF,120'd0} -> mem_addr=0x00010 after t+1; resp_valid=4'b0100 after t+3 with that data; other bits 0; busy low after.
2. All four ports req_re at the same edge, addrs 0x0,0x10,0x20,0x30, rr_ptr=0 -> mem_re on 4 consecutive edges in order 0,1,2,3; resp_valid 0001,0010,0100,1000 on consecutive cycles; rr_ptr=0 at end.
3. Port 0 re-requests on every response; port 3 requests once -> port 3 granted within 2 grants of its request; no port starved over 100 cycles.
4. Port 1 req_re addr 0x5 then again addr 0x9 while pending and not granted -> proto_err=1; exactly one mem_re with addr 0x5; one response to port 1.
5. mem_valid pulsed with empty tag pipe -> resp_err=1, resp_valid stays 0; then mem_valid withheld for a granted fetch -> resp_err stays 1, no response to that port.
6. rst asserted with 2 pending and 1 in flight -> all outputs 0 after the edge; stale mem_valid within MEM_LATENCY edges is ignored with resp_err=0; new request then completes normally in 3 cycles.
